mem_arb_3req: RTL and testbench

MEM_ARB_3REQ -- requirements
Module: mem_arb_3req

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_arb3.sv | 34 +++
 rtl/mem_arb_3req.sv | 214 +++++++++++++++++++++
 tb/tb_mem_arb_3req.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared constants and types for the 3-requester memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int NUM_REQ   = 3;
  localparam int GNT_CNT_W = 32;

  typedef logic [1:0] req_id_t;

  localparam req_id_t ID_C1   = 2'd0;
  localparam req_id_t ID_C2   = 2'd1;
  localparam req_id_t ID_C3   = 2'd2;
  localparam req_id_t ID_NONE = 2'd3;

  function automatic req_id_t rr_next(input req_id_t id);
    return (id == ID_C3) ? ID_C1 : req_id_t'(id + 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb3.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb3 : 3-way round-robin selector, search starts after the last grant
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arb3
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] vld_i,
  input  req_id_t            last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output req_id_t            gnt_id_o
);

  req_id_t w_cand;
  logic    w_found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = ID_NONE;
    w_found  = 1'b0;
    w_cand   = last_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = rr_next(w_cand);
      if (!w_found && vld_i[w_cand]) begin
        gnt_o[w_cand] = 1'b1;
        gnt_id_o      = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arb_3req.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_3req : round-robin arbiter of three requesters onto one memory port;
//                grant counters enabled by macro MEM_ARB_GNT_CNT_EN. Rev 1.0
// ----------------------------------------------------------------------------
module mem_arb_3req
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  c1_req_vld,
  output logic                  c1_req_rdy,
  input  logic                  c1_req_wr,
  input  logic [ADDR_WIDTH-1:0] c1_req_addr,
  input  logic [DATA_WIDTH-1:0] c1_req_data,
  input  logic [MASK_WIDTH-1:0] c1_req_strb,
  output logic [DATA_WIDTH-1:0] c1_rsp_data,
  output logic                  c1_rsp_vld,

  input  logic                  c2_req_vld,
  output logic                  c2_req_rdy,
  input  logic                  c2_req_wr,
  input  logic [ADDR_WIDTH-1:0] c2_req_addr,
  input  logic [DATA_WIDTH-1:0] c2_req_data,
  input  logic [MASK_WIDTH-1:0] c2_req_strb,
  output logic [DATA_WIDTH-1:0] c2_rsp_data,
  output logic                  c2_rsp_vld,

  input  logic                  c3_req_vld,
  output logic                  c3_req_rdy,
  input  logic                  c3_req_wr,
  input  logic [ADDR_WIDTH-1:0] c3_req_addr,
  input  logic [DATA_WIDTH-1:0] c3_req_data,
  input  logic [MASK_WIDTH-1:0] c3_req_strb,
  output logic [DATA_WIDTH-1:0] c3_rsp_data,
  output logic                  c3_rsp_vld,

  output logic [DATA_WIDTH-1:0] m_wr_data,
  output logic [MASK_WIDTH-1:0] m_wr_datastrb,
  output logic [ADDR_WIDTH-1:0] m_wr_addr,
  output logic                  m_rd_en,
  output logic [ADDR_WIDTH-1:0] m_rd_addr,
  input  logic [DATA_WIDTH-1:0] m_rd_data,
  input  logic                  m_rd_data_vld,

  output logic                  err_orphan_rsp,
  output logic [GNT_CNT_W-1:0]  c1_gnt_cnt,
  output logic [GNT_CNT_W-1:0]  c2_gnt_cnt,
  output logic [GNT_CNT_W-1:0]  c3_gnt_cnt
);

  logic [NUM_REQ-1:0]    w_vld, w_wr, w_gnt;
  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
  logic [MASK_WIDTH-1:0] w_strb [NUM_REQ];
  logic [GNT_CNT_W-1:0]  w_gnt_cnt [NUM_REQ];
  req_id_t               w_gnt_id;
  logic                  w_any;

  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [MASK_WIDTH-1:0] w_sel_strb;

  req_id_t               last_q, last_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [MASK_WIDTH-1:0] wr_strb_q, wr_strb_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  req_id_t               id0_q, id0_d, id1_q, id1_d;
  logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_data_q [NUM_REQ];
  logic [DATA_WIDTH-1:0] rsp_data_d [NUM_REQ];
  logic                  err_q, err_d;

  // Masking requests during reset keeps every ready low without extra gating.
  assign w_vld     = rst ? '0 : {c3_req_vld, c2_req_vld, c1_req_vld};
  assign w_wr      = {c3_req_wr, c2_req_wr, c1_req_wr};
  assign w_addr[0] = c1_req_addr;
  assign w_addr[1] = c2_req_addr;
  assign w_addr[2] = c3_req_addr;
  assign w_data[0] = c1_req_data;
  assign w_data[1] = c2_req_data;
  assign w_data[2] = c3_req_data;
  assign w_strb[0] = c1_req_strb;
  assign w_strb[1] = c2_req_strb;
  assign w_strb[2] = c3_req_strb;

  rr_arb3 u_rr_arb3 (
    .vld_i    (w_vld),
    .last_i   (last_q),
    .gnt_o    (w_gnt),
    .gnt_id_o (w_gnt_id)
  );

  assign w_any      = |w_gnt;
  assign c1_req_rdy = w_gnt[0];
  assign c2_req_rdy = w_gnt[1];
  assign c3_req_rdy = w_gnt[2];

  always_comb begin
    w_sel_wr   = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_strb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_wr   = w_wr[i];
        w_sel_addr = w_addr[i];
        w_sel_data = w_data[i];
        w_sel_strb = w_strb[i];
      end
    end
  end

  always_comb begin
    last_d    = w_any ? w_gnt_id : last_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    wr_strb_d = '0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    id0_d     = ID_NONE;
    if (w_any) begin
      if (w_sel_wr) begin
        wr_addr_d = w_sel_addr;
        wr_data_d = w_sel_data;
        wr_strb_d = w_sel_strb;
      end else begin
        rd_en_d   = 1'b1;
        rd_addr_d = w_sel_addr;
        id0_d     = w_gnt_id;
      end
    end
    // id1 lines up with m_rd_data_vld given the one-cycle memory latency.
    id1_d = id0_q;
    err_d = err_q | (m_rd_data_vld && (id1_q == ID_NONE));
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_vld_d[i]  = m_rd_data_vld && (id1_q == req_id_t'(i));
      rsp_data_d[i] = rsp_vld_d[i] ? m_rd_data : rsp_data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= ID_C3;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_strb_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      id0_q     <= ID_NONE;
      id1_q     <= ID_NONE;
      rsp_vld_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) rsp_data_q[i] <= '0;
    end else begin
      last_q    <= last_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      wr_strb_q <= wr_strb_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      id0_q     <= id0_d;
      id1_q     <= id1_d;
      rsp_vld_q <= rsp_vld_d;
      err_q     <= err_d;
      for (int i = 0; i < NUM_REQ; i++) rsp_data_q[i] <= rsp_data_d[i];
    end
  end

`ifdef MEM_ARB_GNT_CNT_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt_cnt
    logic [GNT_CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (w_gnt[gi] && (cnt_q != {GNT_CNT_W{1'b1}})) cnt_d = cnt_q + GNT_CNT_W'(1);
    end
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
    assign w_gnt_cnt[gi] = cnt_q;
  end
`else
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt_cnt_off
    assign w_gnt_cnt[gi] = '0;
  end
`endif

  assign m_wr_data      = wr_data_q;
  assign m_wr_datastrb  = wr_strb_q;
  assign m_wr_addr      = wr_addr_q;
  assign m_rd_en        = rd_en_q;
  assign m_rd_addr      = rd_addr_q;
  assign c1_rsp_vld     = rsp_vld_q[0];
  assign c2_rsp_vld     = rsp_vld_q[1];
  assign c3_rsp_vld     = rsp_vld_q[2];
  assign c1_rsp_data    = rsp_data_q[0];
  assign c2_rsp_data    = rsp_data_q[1];
  assign c3_rsp_data    = rsp_data_q[2];
  assign err_orphan_rsp = err_q;
  assign c1_gnt_cnt     = w_gnt_cnt[0];
  assign c2_gnt_cnt     = w_gnt_cnt[1];
  assign c3_gnt_cnt     = w_gnt_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_3req.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arb_3req : self-checking bench with a 1-cycle-latency memory model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_arb_3req;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int MW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]    vld, wr, rdy, rsp_vld;
  logic [AW-1:0] addr [3];
  logic [DW-1:0] data [3];
  logic [MW-1:0] strb [3];
  logic [DW-1:0] rsp_data [3];
  logic [31:0]   gnt_cnt [3];

  logic [DW-1:0] m_wr_data, m_rd_data;
  logic [MW-1:0] m_wr_datastrb;
  logic [AW-1:0] m_wr_addr, m_rd_addr;
  logic          m_rd_en, m_rd_data_vld, err;

  int n_cmp = 0;
  int n_err = 0;

  mem_arb_3req dut (
    .clk(clk), .rst(rst),
    .c1_req_vld(vld[0]), .c1_req_rdy(rdy[0]), .c1_req_wr(wr[0]), .c1_req_addr(addr[0]),
    .c1_req_data(data[0]), .c1_req_strb(strb[0]), .c1_rsp_data(rsp_data[0]), .c1_rsp_vld(rsp_vld[0]),
    .c2_req_vld(vld[1]), .c2_req_rdy(rdy[1]), .c2_req_wr(wr[1]), .c2_req_addr(addr[1]),
    .c2_req_data(data[1]), .c2_req_strb(strb[1]), .c2_rsp_data(rsp_data[1]), .c2_rsp_vld(rsp_vld[1]),
    .c3_req_vld(vld[2]), .c3_req_rdy(rdy[2]), .c3_req_wr(wr[2]), .c3_req_addr(addr[2]),
    .c3_req_data(data[2]), .c3_req_strb(strb[2]), .c3_rsp_data(rsp_data[2]), .c3_rsp_vld(rsp_vld[2]),
    .m_wr_data(m_wr_data), .m_wr_datastrb(m_wr_datastrb), .m_wr_addr(m_wr_addr),
    .m_rd_en(m_rd_en), .m_rd_addr(m_rd_addr), .m_rd_data(m_rd_data), .m_rd_data_vld(m_rd_data_vld),
    .err_orphan_rsp(err),
    .c1_gnt_cnt(gnt_cnt[0]), .c2_gnt_cnt(gnt_cnt[1]), .c3_gnt_cnt(gnt_cnt[2])
  );

  // Memory model: 16 words indexed by addr[9:6], byte-strobed writes, 1-cycle reads.
  logic [DW-1:0] mem [16] = '{default: '0};
  always @(posedge clk) begin
    m_rd_data_vld <= m_rd_en;
    if (m_rd_en) m_rd_data <= mem[m_rd_addr[9:6]];
    for (int b = 0; b < MW; b++)
      if (m_wr_datastrb[b]) mem[m_wr_addr[9:6]][b*8 +: 8] <= m_wr_data[b*8 +: 8];
  end

  task automatic chk_n(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    vld = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Single request from requester n; returns at the negedge after acceptance.
  task automatic issue(input int n, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] s);
    @(negedge clk);
    vld     = 3'(1 << n);
    wr[n]   = w;
    addr[n] = a;
    data[n] = d;
    strb[n] = s;
    #1 chk_n("issue_rdy", 64'(rdy), 64'(1 << n));
    @(negedge clk);
    vld = '0;
  endtask

  task automatic rd_check(input string nm, input int n, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp_d);
    issue(n, 1'b0, a, '0, '0);
    chk_n({nm, "_rd_en"}, 64'(m_rd_en), 64'd1);
    chk_n({nm, "_rd_addr"}, m_rd_addr, a);
    chk_n({nm, "_strb_idle"}, m_wr_datastrb, 64'd0);
    chk_n({nm, "_rsp_t1"}, 64'(rsp_vld), 64'd0);
    @(negedge clk);
    chk_n({nm, "_rsp_t2"}, 64'(rsp_vld), 64'd0);
    @(negedge clk);
    chk_n({nm, "_rsp_vld"}, 64'(rsp_vld), 64'(1 << n));
    chk_w({nm, "_rsp_data"}, rsp_data[n], exp_d);
    @(negedge clk);
    chk_n({nm, "_rsp_after"}, 64'(rsp_vld), 64'd0);
  endtask

  function automatic int pick(input logic [2:0] v, input int last);
    for (int k = 1; k <= 3; k++)
      if (v[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  typedef struct {
    logic [2:0] vld;
    logic [2:0] exp_rdy;
  } arb_vec_t;

  typedef struct {
    int            id;
    logic [DW-1:0] d;
    int            due;
  } rsp_t;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    arb_vec_t      tbl [16];
    logic [DW-1:0] pat_a, pat_b, pat_c, inv_b, exp_b;
    logic [DW-1:0] ref_mem [16];
    logic [MW-1:0] ones;
    logic [31:0]   exp_cnt [3];
    logic [2:0]    exp_vec;
    logic [DW-1:0] exp_d;
    logic          exp_rd_en, exp_wr;
    logic [AW-1:0] exp_rd_addr, exp_wr_addr;
    logic [DW-1:0] exp_wr_data;
    logic [MW-1:0] exp_strb;
    rsp_t          q [$];
    rsp_t          r;
    int            last_g, g;

    tbl[0]  = '{3'b111, 3'b001};  tbl[1]  = '{3'b111, 3'b010};
    tbl[2]  = '{3'b111, 3'b100};  tbl[3]  = '{3'b111, 3'b001};
    tbl[4]  = '{3'b111, 3'b010};  tbl[5]  = '{3'b111, 3'b100};
    tbl[6]  = '{3'b000, 3'b000};  tbl[7]  = '{3'b010, 3'b010};
    tbl[8]  = '{3'b000, 3'b000};  tbl[9]  = '{3'b101, 3'b100};
    tbl[10] = '{3'b101, 3'b001};  tbl[11] = '{3'b110, 3'b010};
    tbl[12] = '{3'b110, 3'b100};  tbl[13] = '{3'b011, 3'b001};
    tbl[14] = '{3'b100, 3'b100};  tbl[15] = '{3'b111, 3'b001};

    ones  = '1;
    pat_a = {16{32'hA5A5_5A5A}} ^ 512'h0123_4567_89AB_CDEF;
    pat_b = {16{32'h1357_9BDF}};
    pat_c = {16{32'hC0DE_0042}};
    inv_b = ~pat_b;
    exp_b = {pat_b[DW-1:8], inv_b[7:0]};

    vld = '0;
    wr  = '1;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; data[i] = '0; strb[i] = '0;
    end

    // Reset state with all requesters asserting.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vld = 3'b111;
    #1;
    chk_n("rst_rdy", 64'(rdy), 64'd0);
    chk_n("rst_rd_en", 64'(m_rd_en), 64'd0);
    chk_n("rst_strb", m_wr_datastrb, 64'd0);
    chk_n("rst_wr_addr", m_wr_addr, 64'd0);
    chk_n("rst_rd_addr", m_rd_addr, 64'd0);
    chk_w("rst_wr_data", m_wr_data, '0);
    chk_n("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk_w("rst_rsp_data", rsp_data[0], '0);
    chk_n("rst_err", 64'(err), 64'd0);
    for (int i = 0; i < 3; i++) chk_n("rst_gnt_cnt", 64'(gnt_cnt[i]), 64'd0);
    vld = '0;
    rst = 1'b0;

    // Round-robin table: no-op writes, pointer state carried across vectors.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vld = tbl[i].vld;
      #1 chk_n($sformatf("arb_tbl[%0d]", i), 64'(rdy), 64'(tbl[i].exp_rdy));
    end
    @(negedge clk);
    vld = '0;

    // Write by c2 then read-back by c3.
    reset_dut();
    issue(1, 1'b1, 64'h40, pat_a, ones);
    chk_n("a_wr_addr", m_wr_addr, 64'h40);
    chk_w("a_wr_data", m_wr_data, pat_a);
    chk_n("a_wr_strb", m_wr_datastrb, ones);
    chk_n("a_wr_rd_en", 64'(m_rd_en), 64'd0);
    @(negedge clk);
    chk_n("a_idle_strb", m_wr_datastrb, 64'd0);
    rd_check("a_c3", 2, 64'h40, pat_a);

    // Partial-byte write: only byte 0 changes.
    issue(0, 1'b1, 64'h80, pat_b, ones);
    issue(0, 1'b1, 64'h80, inv_b, 64'h0000_0000_0000_0001);
    chk_n("b_wr_strb", m_wr_datastrb, 64'h1);
    rd_check("b_c2", 1, 64'h80, exp_b);
    chk_w("b_mem_model", mem[2], exp_b);

    // Back-to-back reads from three requesters.
    issue(0, 1'b1, 64'h0, pat_c, ones);
    wr = '0;
    addr[0] = 64'h0; addr[1] = 64'h40; addr[2] = 64'h80;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vld = 3'(1 << i);
      #1 chk_n("c_b2b_rdy", 64'(rdy), 64'(1 << i));
    end
    @(negedge clk);
    vld = '0;
    chk_n("c_rsp0_vld", 64'(rsp_vld), 64'b001);
    chk_w("c_rsp0_data", rsp_data[0], pat_c);
    @(negedge clk);
    chk_n("c_rsp1_vld", 64'(rsp_vld), 64'b010);
    chk_w("c_rsp1_data", rsp_data[1], pat_a);
    @(negedge clk);
    chk_n("c_rsp2_vld", 64'(rsp_vld), 64'b100);
    chk_w("c_rsp2_data", rsp_data[2], exp_b);
    @(negedge clk);
    chk_n("c_rsp_end", 64'(rsp_vld), 64'd0);

    // Grant counters.
    reset_dut();
    wr = '1;
    for (int i = 0; i < 3; i++) strb[i] = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      vld = (i < 10) ? 3'b001 : 3'b100;
      #1 chk_n("cnt_rdy", 64'(rdy), 64'(vld));
    end
    @(negedge clk);
    vld = '0;
    @(negedge clk);
`ifdef MEM_ARB_GNT_CNT_EN
    exp_cnt[0] = 32'd10; exp_cnt[1] = 32'd0; exp_cnt[2] = 32'd4;
`else
    exp_cnt[0] = 32'd0;  exp_cnt[1] = 32'd0; exp_cnt[2] = 32'd0;
`endif
    chk_n("gnt_cnt_c1", 64'(gnt_cnt[0]), 64'(exp_cnt[0]));
    chk_n("gnt_cnt_c2", 64'(gnt_cnt[1]), 64'(exp_cnt[1]));
    chk_n("gnt_cnt_c3", 64'(gnt_cnt[2]), 64'(exp_cnt[2]));

    // Reset the cycle after a read is accepted; the late data is an orphan.
    issue(0, 1'b0, 64'h0, '0, '0);
    chk_n("d_rd_en", 64'(m_rd_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    vld = 3'b111;
    #1;
    chk_n("d_rst_rdy", 64'(rdy), 64'd0);
    chk_n("d_rst_rd_en", 64'(m_rd_en), 64'd0);
    chk_n("d_rst_cnt_c1", 64'(gnt_cnt[0]), 64'd0);
    chk_n("d_rst_err", 64'(err), 64'd0);
    vld = '0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_n("d_no_rsp", 64'(rsp_vld), 64'd0);
      chk_n("d_orphan", 64'(err), 64'd1);
    end

    // Randomized traffic against a transaction-level reference.
    reset_dut();
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
    last_g    = 2;
    exp_rd_en = 1'b0;
    exp_wr    = 1'b0;
    exp_strb  = '0;
    exp_rd_addr = '0; exp_wr_addr = '0; exp_wr_data = '0;
    for (int cyc = 0; cyc < 404; cyc++) begin
      @(negedge clk);
      chk_n("rnd_rd_en", 64'(m_rd_en), 64'(exp_rd_en));
      chk_n("rnd_strb", m_wr_datastrb, exp_strb);
      if (exp_rd_en) chk_n("rnd_rd_addr", m_rd_addr, exp_rd_addr);
      if (exp_wr) begin
        chk_n("rnd_wr_addr", m_wr_addr, exp_wr_addr);
        chk_w("rnd_wr_data", m_wr_data, exp_wr_data);
      end
      exp_vec = '0;
      exp_d   = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        exp_vec[r.id] = 1'b1;
        exp_d = r.d;
      end
      chk_n("rnd_rsp_vld", 64'(rsp_vld), 64'(exp_vec));
      for (int n = 0; n < 3; n++)
        if (exp_vec[n]) chk_w("rnd_rsp_data", rsp_data[n], exp_d);

      for (int n = 0; n < 3; n++) begin
        vld[n]  = (cyc < 400) && ($urandom_range(0, 2) != 0);
        wr[n]   = 1'($urandom_range(0, 1));
        addr[n] = 64'($urandom_range(0, 15)) << 6;
        for (int k = 0; k < 16; k++) data[n][k*32 +: 32] = $urandom;
        case ($urandom_range(0, 2))
          0:       strb[n] = '0;
          1:       strb[n] = '1;
          default: strb[n] = {$urandom, $urandom};
        endcase
      end
      #1;
      g = pick(vld, last_g);
      chk_n("rnd_rdy", 64'(rdy), (g < 0) ? 64'd0 : 64'(1 << g));
      exp_rd_en = 1'b0;
      exp_wr    = 1'b0;
      exp_strb  = '0;
      if (g >= 0) begin
        last_g = g;
        if (wr[g]) begin
          exp_wr      = 1'b1;
          exp_wr_addr = addr[g];
          exp_wr_data = data[g];
          exp_strb    = strb[g];
          for (int b = 0; b < MW; b++)
            if (strb[g][b]) ref_mem[addr[g][9:6]][b*8 +: 8] = data[g][b*8 +: 8];
        end else begin
          exp_rd_en   = 1'b1;
          exp_rd_addr = addr[g];
          q.push_back('{g, ref_mem[addr[g][9:6]], cyc + 3});
        end
      end
    end
    vld = '0;
    chk_n("rnd_queue_drained", 64'(q.size()), 64'd0);
    chk_n("rnd_no_orphan", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
